// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing engine.
package vga_pkg;
   typedef enum logic {IDLE, RUN} vga_state_t;

   typedef struct packed {
      int unsigned hdisp, hfp, hpulse, hbp;
      int unsigned vdisp, vfp, vpulse, vbp;
   } vga_timing_t;

   function automatic int unsigned vga_total(int unsigned disp, int unsigned fp,
                                             int unsigned pulse, int unsigned bp);
      return disp + fp + pulse + bp;
   endfunction

   // Bit width for a 0..n-1 range, never zero.
   function automatic int unsigned vga_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/vga_timing_engine_if.sv
// Display FIFO read port plus video output bundle of the VGA timing engine.
interface vga_timing_engine_if #(
   parameter int DATA_W = 24,
   parameter int X_W    = 10,
   parameter int Y_W    = 9
);
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_rempty;
   logic              fifo_read;
   logic              hs, vs, blank;
   logic [DATA_W-1:0] rgb;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic              frame_start, line_start;

   modport master (input  fifo_rdata, fifo_rempty,
                   output fifo_read, hs, vs, blank, rgb, x, y, frame_start, line_start);
   modport slave  (output fifo_rdata, fifo_rempty,
                   input  fifo_read, hs, vs, blank, rgb, x, y, frame_start, line_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: front porch, pulse, back porch, then active region.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int DISP  = 800,
   parameter int FP    = 40,
   parameter int PULSE = 48,
   parameter int BP    = 40,
   localparam int TOTAL = vga_total(DISP, FP, PULSE, BP),
   localparam int CW    = vga_w(TOTAL),
   localparam int PW    = vga_w(DISP)
) (
   input  logic          pixel_clk,
   input  logic          pixel_rst,
   input  logic          enable,
   input  logic          step,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          sync_active,
   output logic          active,
   output logic [PW-1:0] pos
);
   localparam int OFF = FP + PULSE + BP;

   // Disabled means parked at zero so RUN always starts from the top-left.
   always_ff @(posedge pixel_clk) begin
      if (pixel_rst || !enable) count <= '0;
      else if (step)            count <= wrap ? '0 : count + 1'b1;
   end

   assign wrap        = (count == CW'(TOTAL - 1));
   assign sync_active = (count >= CW'(FP)) && (count < CW'(FP + PULSE));
   assign active      = (count >= CW'(OFF));
   assign pos         = PW'(count - CW'(OFF));
endmodule

// File: rtl/vga_timing_engine.sv
// VGA timing generator with FIFO pixel fetch, start/graceful stop and sticky underflow.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_engine
   import vga_pkg::*;
#(
   parameter int HDISP  = 800,
   parameter int VDISP  = 480,
   parameter int HFP    = 40,
   parameter int HPULSE = 48,
   parameter int HBP    = 40,
   parameter int VFP    = 13,
   parameter int VPULSE = 3,
   parameter int VBP    = 29,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0,
   parameter int DATA_W = 24
) (
   input  logic pixel_clk,
   input  logic pixel_rst,
   input  logic start,
   input  logic stop_req,
   input  logic underflow_clr,
`ifdef VGA_TEST_PATTERN_EN
   input  logic pattern_en,
`endif
   output logic busy,
   output logic underflow,
   vga_timing_engine_if.master vif
);
   localparam vga_timing_t TIM = '{hdisp: HDISP, hfp: HFP, hpulse: HPULSE, hbp: HBP,
                                   vdisp: VDISP, vfp: VFP, vpulse: VPULSE, vbp: VBP};
   localparam int HCW = vga_w(vga_total(HDISP, HFP, HPULSE, HBP));
   localparam int VCW = vga_w(vga_total(VDISP, VFP, VPULSE, VBP));
   localparam int XW  = vga_w(HDISP);
   localparam int YW  = vga_w(VDISP);

   vga_state_t state, state_nxt;
   logic stop_pend, stop_pend_nxt, run;
   logic [HCW-1:0] h_cnt;
   logic [VCW-1:0] v_cnt;
   logic h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
   logic [XW-1:0] h_pos, x_q;
   logic [YW-1:0] v_pos, y_q;
   logic hs_q, vs_q, blank_q, fs_q, ls_q, uf_q, pix_rd, uf_set;

   assign run = (state == RUN);

   vga_axis_counter #(.DISP(TIM.hdisp), .FP(TIM.hfp), .PULSE(TIM.hpulse), .BP(TIM.hbp)) u_h (
      .pixel_clk, .pixel_rst, .enable(run), .step(1'b1),
      .count(h_cnt), .wrap(h_wrap), .sync_active(h_sync), .active(h_act), .pos(h_pos));

   vga_axis_counter #(.DISP(TIM.vdisp), .FP(TIM.vfp), .PULSE(TIM.vpulse), .BP(TIM.vbp)) u_v (
      .pixel_clk, .pixel_rst, .enable(run), .step(h_wrap),
      .count(v_cnt), .wrap(v_wrap), .sync_active(v_sync), .active(v_act), .pos(v_pos));

   always_ff @(posedge pixel_clk) begin
      if (pixel_rst) begin
         state     <= IDLE;
         stop_pend <= 1'b0;
      end else begin
         state     <= state_nxt;
         stop_pend <= stop_pend_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      stop_pend_nxt = stop_pend;
      case (state)
         IDLE: begin
            stop_pend_nxt = 1'b0;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            if (stop_req) stop_pend_nxt = 1'b1;
            // Stop only after the very last pixel of the frame.
            if (h_wrap && v_wrap && (stop_pend || stop_req)) begin
               state_nxt     = IDLE;
               stop_pend_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs trail the counters by one cycle; the final RUN cycle still emits its pixel.
   always_ff @(posedge pixel_clk) begin
      if (pixel_rst || !run) begin
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
      end else begin
         hs_q    <= h_sync ? HS_POL : ~HS_POL;
         vs_q    <= v_sync ? VS_POL : ~VS_POL;
         blank_q <= h_act && v_act;
         x_q     <= (h_act && v_act) ? h_pos : '0;
         y_q     <= (h_act && v_act) ? v_pos : '0;
         fs_q    <= (h_cnt == '0) && (v_cnt == '0);
         ls_q    <= (h_cnt == '0);
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   localparam int CH = DATA_W / 3;
   logic [2:0] bar;
   assign bar    = 3'((32'(x_q) * 8) / HDISP);
   assign pix_rd = blank_q && !vif.fifo_rempty && !pattern_en;
   assign uf_set = blank_q && vif.fifo_rempty && !pattern_en;
   assign vif.rgb = pattern_en ? (blank_q ? {{CH{bar[2]}}, {CH{bar[1]}}, {CH{bar[0]}}} : '0)
                               : (pix_rd ? vif.fifo_rdata : '0);
`else
   assign pix_rd  = blank_q && !vif.fifo_rempty;
   assign uf_set  = blank_q && vif.fifo_rempty;
   assign vif.rgb = pix_rd ? vif.fifo_rdata : '0;
`endif

   // Set has priority over clear so a fresh underflow is never lost.
   always_ff @(posedge pixel_clk) begin
      if (pixel_rst)          uf_q <= 1'b0;
      else if (uf_set)        uf_q <= 1'b1;
      else if (underflow_clr) uf_q <= 1'b0;
   end

   assign vif.fifo_read   = pix_rd;
   assign vif.hs          = hs_q;
   assign vif.vs          = vs_q;
   assign vif.blank       = blank_q;
   assign vif.x           = x_q;
   assign vif.y           = y_q;
   assign vif.frame_start = fs_q;
   assign vif.line_start  = ls_q;
   assign busy            = run;
   assign underflow       = uf_q;
endmodule
